// File: rtl/alu_pkg.sv
// Shared ALU types: operand width, half width, partial-product record.
// Optional feature macro: MUL_FLUSH_EN (adds a pipeline flush input).
package alu_pkg;

  localparam int XLEN = 64;
  localparam int HALF = 32;
  localparam int PPW  = 2 * HALF + 2;
  localparam int RESW = 2 * XLEN;

  typedef struct packed {
    logic           vld;
    logic [PPW-1:0] ll;
    logic [PPW-1:0] lh;
    logic [PPW-1:0] hl;
    logic [PPW-1:0] hh;
  } pp_t;

  function automatic logic [RESW-1:0] sext_pp(
    input logic [PPW-1:0] p
  );
    return {{(RESW-PPW){p[PPW-1]}}, p};
  endfunction

endpackage

// File: rtl/mul_pp33.sv
// 33x33 signed multiplier producing a 66-bit partial product.
// Unsigned halves are fed in zero-extended to share this block.
module mul_pp33
  import alu_pkg::*;
(
  input  logic [HALF:0]  x_i,
  input  logic [HALF:0]  y_i,
  output logic [PPW-1:0] p_o
);

  assign p_o = $signed(x_i) * $signed(y_i);

endmodule

// File: rtl/alu_mul.sv
// Two-stage 64x64 -> 128 signed/unsigned multiplier with valid strobe.
// Optional feature macro: MUL_FLUSH_EN (adds flush input).
module alu_mul
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sign,
`ifdef MUL_FLUSH_EN
  input  logic            flush,
`endif
  output logic            valid_out,
  output logic [RESW-1:0] res
);

  logic flush_w;

`ifdef MUL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // hi halves carry the 65th (sign-extension) bit
  logic [HALF:0] a_hi;
  logic [HALF:0] a_lo;
  logic [HALF:0] b_hi;
  logic [HALF:0] b_lo;

  assign a_hi = {sign & a[XLEN-1], a[XLEN-1:HALF]};
  assign a_lo = {1'b0, a[HALF-1:0]};
  assign b_hi = {sign & b[XLEN-1], b[XLEN-1:HALF]};
  assign b_lo = {1'b0, b[HALF-1:0]};

  logic [PPW-1:0] ll_w;
  logic [PPW-1:0] lh_w;
  logic [PPW-1:0] hl_w;
  logic [PPW-1:0] hh_w;

  mul_pp33 u_ll (
    .x_i (a_lo),
    .y_i (b_lo),
    .p_o (ll_w)
  );

  mul_pp33 u_lh (
    .x_i (a_lo),
    .y_i (b_hi),
    .p_o (lh_w)
  );

  mul_pp33 u_hl (
    .x_i (a_hi),
    .y_i (b_lo),
    .p_o (hl_w)
  );

  mul_pp33 u_hh (
    .x_i (a_hi),
    .y_i (b_hi),
    .p_o (hh_w)
  );

  pp_t pp_d;
  pp_t pp_q;

  always_comb begin
    pp_d     = '0;
    pp_d.vld = valid_in & ~flush_w;
    pp_d.ll  = ll_w;
    pp_d.lh  = lh_w;
    pp_d.hl  = hl_w;
    pp_d.hh  = hh_w;
  end

  logic [RESW-1:0] res_d;
  logic [RESW-1:0] res_q;
  logic            vout_d;
  logic            vout_q;

  always_comb begin
    res_d = sext_pp(pp_q.ll)
          + (sext_pp(pp_q.lh) << HALF)
          + (sext_pp(pp_q.hl) << HALF)
          + (sext_pp(pp_q.hh) << (2 * HALF));
    vout_d = pp_q.vld & ~flush_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pp_q.vld <= 1'b0;
      vout_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      pp_q.vld <= pp_d.vld;
      vout_q   <= vout_d;
      // data only moves with a live slot
      if (valid_in) begin
        pp_q.ll <= pp_d.ll;
        pp_q.lh <= pp_d.lh;
        pp_q.hl <= pp_d.hl;
        pp_q.hh <= pp_d.hh;
      end
      if (vout_d) begin
        res_q <= res_d;
      end
    end
  end

  assign valid_out = vout_q;
  assign res       = res_q;

endmodule

// File: tb/tb_alu_mul.sv
// Scoreboard bench for alu_mul: random operands vs a 128-bit model.
module tb_alu_mul;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         sign;
  logic         flush;
  logic         valid_out;
  logic [127:0] res;

  always #5 clk = ~clk;

  alu_mul dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .sign      (sign),
`ifdef MUL_FLUSH_EN
    .flush     (flush),
`endif
    .valid_out (valid_out),
    .res       (res)
  );

  typedef struct {
    logic [127:0] exp;
    int           due;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] x,
                                           input logic [63:0] y,
                                           input logic s);
    logic [127:0] xe;
    logic [127:0] ye;
    xe = s ? {{64{x[63]}}, x} : {64'd0, x};
    ye = s ? {{64{y[63]}}, y} : {64'd0, y};
    return xe * ye;
  endfunction

  // called at a negedge; result due two edges later
  task automatic issue(input logic [63:0] x, input logic [63:0] y,
                       input logic s, input logic [127:0] exp);
    ent_t e;
    valid_in = 1'b1;
    a        = x;
    b        = y;
    sign     = s;
    e.exp    = exp;
    e.due    = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle();
    valid_in = 1'b0;
    a        = 64'($urandom);
    b        = 64'($urandom);
    sign     = 1'($urandom);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {32'($urandom), 32'($urandom)};
    case ($urandom_range(0, 5))
      0: v = 64'hFFFF_FFFF_FFFF_FFFF;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = {32'd0, v[31:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic issue_rnd();
    logic [63:0] x;
    logic [63:0] y;
    logic        s;
    x = rnd64();
    y = rnd64();
    s = 1'($urandom);
    issue(x, y, s, ref_mul(x, y, s));
  endtask

  // monitor
  logic [127:0] last_res;
  initial begin
    ent_t e;
    last_res = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_valid_out", 128'(valid_out), 128'd0);
        chk("rst_res", res, 128'd0);
        last_res = '0;
      end else if (valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 128'(valid_out), 128'd0);
        end else begin
          e = sb.pop_front();
          chk("product", res, e.exp);
          chk("latency", 128'(cyc), 128'(e.due));
        end
        last_res = res;
      end else begin
        chk("valid_out_known", 128'(valid_out), 128'd0);
        chk("res_hold", res, last_res);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    ent_t keep[$];
    rst      = 1'b1;
    flush    = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    sign     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          128'hFFFFFFFFFFFFFFFE0000000000000001);
    repeat (3) begin @(negedge clk); idle(); end
    @(negedge clk);
    issue(64'h8000_0000_0000_0000, 64'd2, 1'b0,
          128'h00000000000000010000000000000000);
    @(negedge clk);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
          128'd1);
    @(negedge clk);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1,
          128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE);
    @(negedge clk);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          128'h40000000000000000000000000000000);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);

    repeat (10) begin
      issue_rnd();
      @(negedge clk);
    end
    idle();

    repeat (40) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) issue_rnd();
      else idle();
    end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);

    // reset with ops in flight; the op still in stage 1 is dropped
    issue_rnd();
    @(negedge clk);
    issue_rnd();
    @(negedge clk);
    issue_rnd();
    rst = 1'b1;
    keep.delete();
    foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
    sb = keep;
    @(negedge clk);
    rst = 1'b0;
    idle();
    repeat (4) @(negedge clk);

    repeat (8) begin
      issue_rnd();
      @(negedge clk);
    end
    idle();
    repeat (5) @(negedge clk);

    chk("drain_empty", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mul.md
Name: alu_mul

Overview:
64x64 integer multiplier for the core ALU. It produces the full 128-bit product and supports signed (two's-complement) and unsigned operands.
- The `sign` input selects the mode per operation.
- The block is pipelined with a valid strobe and sits in the ALU execute path alongside the other ALU sub-units.

Parameters:
- XLEN, 64: operand width. The product is 2*XLEN wide. Only 64 is required to be supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  operands on a/b/sign are valid this cycle.
- a  in  64  multiplicand.
- b  in  64  multiplier.
- sign  in  1  1 = both operands signed two's-complement; 0 = both unsigned.
- valid_out  out  1  res holds a completed product.
- res  out  128  full product, two's-complement when sign=1.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high. On a clk edge with rst=1, valid_out and all pipeline valid bits clear to 0, and res clears to 0.
- Arithmetic: each operand is extended to 65 bits as {sign & msb, operand}. The signed 65x65 product is computed and the low 128 bits go to res.
  - Unsigned mode: res equals a*b exactly.
  - Signed mode: res equals $signed(a)*$signed(b) exactly, with no overflow possible.
- Split: operands are split into hi/lo 32-bit halves, forming four partial products.
  - lo*lo is 32x32 unsigned.
  - hi halves are treated as 33-bit with the sign extension bit.
  - The cross and hi*hi products are signed 33x33.
- Stage 1 (edge after valid_in): register the four partial products plus valid.
- Stage 2 (next edge): shift-add the partial products into 128 bits, register res, and assert valid_out.
- Latency: exactly 2 cycles from valid_in to valid_out.
- Throughput: one operation per cycle, with no backpressure. A new operation may be issued every cycle and results emerge in issue order.
- res holds its last value while valid_out=0. Consumers must qualify res with valid_out.
- Inputs are sampled only when valid_in=1. Pipeline registers for invalid slots may hold stale data.
- Reset mid-operation: in-flight operations are discarded. Neither valid_out nor any pipeline valid bit reasserts for them.
- valid_in=1 during a reset cycle is ignored.

Optional Feature:
- MUL_FLUSH_EN
  - Defined: adds input port `flush` (1 bit). A cycle with flush=1 clears both pipeline valid bits and valid_out on that edge; res is unchanged. If valid_in=1 in the same cycle, that operation is also dropped.
  - Undefined: there is no flush port, and the pipeline drains only by normal progression or rst.

Decomposition:
- Shared package alu_pkg holds:
  - the XLEN constant;
  - a typedef for the partial-product record (four products plus valid);
  - the localparam for the 32-bit half width.
- One sub-module, mul_pp33: a 33x33 signed multiplier, instantiated four times.
  - The lo*lo product uses zero-extended inputs, so it can share the same module.
- Shift-add and pipeline control stay in alu_mul.

Test Plan:
- Unsigned extremes: sign=0, a=b=FFFFFFFFFFFFFFFF -> res=FFFFFFFFFFFFFFFE0000000000000001 two cycles later, with valid_out=1 for one cycle.
- Unsigned carry: sign=0, a=8000000000000000, b=2 -> res=00000000000000010000000000000000.
- Signed: sign=1, a=b=FFFFFFFFFFFFFFFF (-1*-1) -> res=1.
- Signed: sign=1, a=-1, b=2 -> res=FFFF...FFFE (128-bit -2).
- Signed min: sign=1, a=b=8000000000000000 -> res=40000000000000000000000000000000.
- Back-to-back and reset:
  - Ten random signed/unsigned pairs on consecutive cycles, compared in order against a reference model.
  - Then rst=1 while two operations are in flight -> valid_out stays 0 and res=0 the following cycle.
